// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI field constants for the SRAM-like to AXI3 bridge.
package cpu_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AWW,
      ST_B
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_NONE = 2'd3;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe from SRAM-like transfer size and low address bits.
module axi_wstrb_gen
   import cpu_axi_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b0000;
      case (size)
         SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
         SIZE_WORD: wstrb = 4'b1111;
         // size 3 is a legal write that touches no bytes
         default:   wstrb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Merges instruction (read-only) and data SRAM-like ports onto one AXI3 master;
// one single-beat transaction in flight, data port has priority.
module sramlike_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter int ID_W = 4
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            inst_req,
   input  logic            inst_wr,
   input  logic [1:0]      inst_size,
   input  logic [31:0]     inst_addr,
   input  logic [31:0]     inst_wdata,
   output logic [31:0]     inst_rdata,
   output logic            inst_addr_ok,
   output logic            inst_data_ok,

   input  logic            data_req,
   input  logic            data_wr,
   input  logic [1:0]      data_size,
   input  logic [31:0]     data_addr,
   input  logic [31:0]     data_wdata,
   output logic [31:0]     data_rdata,
   output logic            data_addr_ok,
   output logic            data_data_ok,

   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [3:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,

   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,

   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [3:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,

   output logic [ID_W-1:0] wid,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,

   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   state_t      state_reg;
   logic        src_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        aw_done_reg;
   logic        w_done_reg;
   logic        arvalid_reg;
   logic        rready_reg;
   logic        awvalid_reg;
   logic        wvalid_reg;
   logic        bready_reg;

   logic idle;
   logic grant_data;
   logic grant_inst;
   logic aw_fire;
   logic w_fire;
   logic aw_ok;
   logic w_ok;
   logic r_fire;
   logic b_fire;
   logic unused_inputs;

   // Responses are never checked and the inst port is read-only.
   assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, inst_wr, inst_wdata};

   assign idle       = (state_reg == ST_IDLE) && !rst;
   assign grant_data = idle && data_req;
   assign grant_inst = idle && inst_req && !data_req;

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;

   assign aw_fire = awvalid_reg && awready;
   assign w_fire  = wvalid_reg && wready;
   assign aw_ok   = aw_done_reg || aw_fire;
   assign w_ok    = w_done_reg || w_fire;
   assign r_fire  = (state_reg == ST_R) && rvalid;
   assign b_fire  = (state_reg == ST_B) && bvalid;

   assign inst_data_ok = r_fire && (src_reg == ID_INST);
   assign data_data_ok = (r_fire && (src_reg == ID_DATA)) || b_fire;
   assign inst_rdata   = inst_data_ok ? rdata : 32'd0;
   assign data_rdata   = (r_fire && (src_reg == ID_DATA)) ? rdata : 32'd0;

   assign arid    = ID_W'(src_reg);
   assign araddr  = addr_reg;
   assign arlen   = AXI_LEN_SINGLE;
   assign arsize  = {1'b0, size_reg};
   assign arburst = AXI_BURST_INCR;
   assign arvalid = arvalid_reg;
   assign rready  = rready_reg;

   assign awid    = ID_W'(src_reg);
   assign awaddr  = addr_reg;
   assign awlen   = AXI_LEN_SINGLE;
   assign awsize  = {1'b0, size_reg};
   assign awburst = AXI_BURST_INCR;
   assign awvalid = awvalid_reg;

   assign wid    = ID_W'(src_reg);
   assign wdata  = wdata_reg;
   assign wlast  = 1'b1;
   assign wvalid = wvalid_reg;
   assign bready = bready_reg;

   axi_wstrb_gen u_wstrb (
      .size    (size_reg),
      .addr_lo (addr_reg[1:0]),
      .wstrb   (wstrb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         src_reg     <= 1'b0;
         size_reg    <= 2'd0;
         addr_reg    <= 32'd0;
         wdata_reg   <= 32'd0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         arvalid_reg <= 1'b0;
         rready_reg  <= 1'b0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         bready_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_data || grant_inst) begin
                  src_reg   <= grant_data ? ID_DATA : ID_INST;
                  size_reg  <= grant_data ? data_size : inst_size;
                  addr_reg  <= grant_data ? data_addr : inst_addr;
                  wdata_reg <= grant_data ? data_wdata : 32'd0;
                  if (grant_data && data_wr) begin
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= ST_AWW;
                  end else begin
                     arvalid_reg <= 1'b1;
                     state_reg   <= ST_AR;
                  end
               end
            end
            ST_AR: begin
               if (arready) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= ST_R;
               end
            end
            ST_R: begin
               if (rvalid) begin
                  rready_reg <= 1'b0;
                  state_reg  <= ST_IDLE;
               end
            end
            ST_AWW: begin
               if (aw_fire) begin
                  awvalid_reg <= 1'b0;
                  aw_done_reg <= 1'b1;
               end
               if (w_fire) begin
                  wvalid_reg <= 1'b0;
                  w_done_reg <= 1'b1;
               end
               // Later assignments clear the flags when both sides finish.
               if (aw_ok && w_ok) begin
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
                  bready_reg  <= 1'b1;
                  state_reg   <= ST_B;
               end
            end
            ST_B: begin
               if (bvalid) begin
                  bready_reg <= 1'b0;
                  state_reg  <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench: directed table, hand sequences and randomized transfers
// checked against a transaction-level model of the bridge.
module tb_sramlike_axi_bridge;

   localparam int ID_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            inst_req, inst_wr;
   logic [1:0]      inst_size;
   logic [31:0]     inst_addr, inst_wdata, inst_rdata;
   logic            inst_addr_ok, inst_data_ok;
   logic            data_req, data_wr;
   logic [1:0]      data_size;
   logic [31:0]     data_addr, data_wdata, data_rdata;
   logic            data_addr_ok, data_data_ok;
   logic [ID_W-1:0] arid, awid, wid, rid, bid;
   logic [31:0]     araddr, awaddr, wdata, rdata;
   logic [3:0]      arlen, awlen, wstrb;
   logic [2:0]      arsize, awsize;
   logic [1:0]      arburst, awburst, rresp, bresp;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sramlike_axi_bridge #(.ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference strobe: one lane per byte covered by the access.
   function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
      int lane;
      lane = int'(a[1:0]);
      case (sz)
         2'd0: return 4'(1 << lane);
         2'd1: return 4'(3 << ((lane / 2) * 2));
         2'd2: return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   task automatic do_read(input bit d, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] rd, input logic [1:0] resp,
                          input int ard, input int rdd);
      if (d) begin
         data_req = 1'b1; data_wr = 1'b0; data_addr = a; data_size = sz; data_wdata = $urandom;
      end else begin
         inst_req = 1'b1; inst_wr = 1'($urandom); inst_addr = a; inst_size = sz; inst_wdata = $urandom;
      end
      #1;
      chk("addr_ok", 32'(d ? data_addr_ok : inst_addr_ok), 32'd1);
      chk("other_addr_ok", 32'(d ? inst_addr_ok : data_addr_ok), 32'd0);
      @(posedge clk); #1;
      if (d) data_req = 1'b0; else inst_req = 1'b0;
      for (int i = 0; i <= ard; i++) begin
         chk("arvalid", 32'(arvalid), 32'd1);
         chk("araddr", araddr, a);
         chk("arid", 32'(arid), 32'(d));
         chk("arsize", 32'(arsize), 32'(sz));
         chk("arlen_arburst", 32'({arlen, arburst}), 32'h1);
         chk("awvalid_in_read", 32'(awvalid), 32'd0);
         arready = (i == ard);
         @(posedge clk); #1;
         arready = 1'b0;
      end
      for (int i = 0; i <= rdd; i++) begin
         chk("arvalid_dropped", 32'(arvalid), 32'd0);
         chk("rready", 32'(rready), 32'd1);
         rvalid = (i == rdd);
         rdata  = rvalid ? rd : $urandom;
         rresp  = resp;
         rid    = 4'($urandom);
         #1;
         chk("own_data_ok", 32'(d ? data_data_ok : inst_data_ok), 32'(rvalid));
         chk("other_data_ok", 32'(d ? inst_data_ok : data_data_ok), 32'd0);
         chk("addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
         if (rvalid) begin
            chk("own_rdata", d ? data_rdata : inst_rdata, rd);
            chk("other_rdata", d ? inst_rdata : data_rdata, 32'd0);
         end
         @(posedge clk); #1;
         rvalid = 1'b0;
      end
      chk("rready_after", 32'(rready), 32'd0);
      chk("data_ok_after", 32'({inst_data_ok, data_data_ok}), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input logic [3:0] exp_strb, input logic [2:0] exp_awsize,
                           input int aw_d, input int w_d, input int b_d);
      bit aw_hs, w_hs;
      int k;
      data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_size = sz; data_wdata = wd;
      #1;
      chk("wr_addr_ok", 32'(data_addr_ok), 32'd1);
      chk("wr_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      @(posedge clk); #1;
      data_req = 1'b0;
      aw_hs = 1'b0; w_hs = 1'b0; k = 0;
      while (!(aw_hs && w_hs)) begin
         if (k > 40) begin
            checks++; errors++;
            $display("FAIL aww_timeout: handshakes not complete after %0d cycles", k);
            break;
         end
         chk("awvalid", 32'(awvalid), 32'(!aw_hs));
         chk("wvalid", 32'(wvalid), 32'(!w_hs));
         chk("bready_early", 32'(bready), 32'd0);
         chk("arvalid_in_write", 32'(arvalid), 32'd0);
         chk("awaddr", awaddr, a);
         chk("awsize", 32'(awsize), 32'(exp_awsize));
         chk("awfields", 32'({awid, awlen, awburst}), {22'd0, 4'd1, 4'd0, 2'b01});
         chk("wstrb", 32'(wstrb), 32'(exp_strb));
         chk("wdata", wdata, wd);
         chk("wid_wlast", 32'({wid, wlast}), 32'h3);
         awready = (k >= aw_d);
         wready  = (k >= w_d);
         @(posedge clk); #1;
         if (awready) aw_hs = 1'b1;
         if (wready)  w_hs = 1'b1;
         awready = 1'b0; wready = 1'b0;
         k++;
      end
      for (int i = 0; i <= b_d; i++) begin
         chk("bready", 32'(bready), 32'd1);
         chk("aw_w_dropped", 32'({awvalid, wvalid}), 32'd0);
         bvalid = (i == b_d);
         bresp  = 2'($urandom);
         bid    = 4'($urandom);
         #1;
         chk("wr_data_ok", 32'(data_data_ok), 32'(bvalid));
         chk("wr_inst_data_ok", 32'(inst_data_ok), 32'd0);
         @(posedge clk); #1;
         bvalid = 1'b0;
      end
      chk("bready_after", 32'(bready), 32'd0);
      chk("wr_data_ok_after", 32'(data_data_ok), 32'd0);
   endtask

   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  exp_wstrb;
      logic [2:0]  exp_awsize;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{2'd0, 32'h8000_0003, 32'h0000_00AB, 4'b1000, 3'd0};
      tbl[1] = '{2'd0, 32'h8000_0001, 32'h0000_CD00, 4'b0010, 3'd0};
      tbl[2] = '{2'd1, 32'h8000_0002, 32'h1234_0000, 4'b1100, 3'd1};
      tbl[3] = '{2'd1, 32'h8000_0000, 32'h0000_5678, 4'b0011, 3'd1};
      tbl[4] = '{2'd2, 32'h8000_0004, 32'hA5A5_5A5A, 4'b1111, 3'd2};
      tbl[5] = '{2'd3, 32'h8000_0001, 32'hFFFF_FFFF, 4'b0000, 3'd3};

      rst = 1'b1;
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
      chk("rst_readys", 32'({rready, bready}), 32'd0);
      chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Boot fetch, zero-wait slave.
      do_read(1'b0, 32'hBFC0_0000, 2'd2, 32'h3C08_BFC0, 2'b00, 0, 0);

      // Both request: data first, inst held and granted right after.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0004; inst_size = 2'd2;
      do_read(1'b1, 32'h8000_1000, 2'd2, 32'h1234_5678, 2'b00, 0, 0);
      do_read(1'b0, 32'hBFC0_0004, 2'd2, 32'h2408_0001, 2'b00, 0, 0);

      for (int i = 0; i < 6; i++)
         do_write(tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].exp_wstrb,
                  tbl[i].exp_awsize, 0, 0, 0);

      do_write(32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 4'hF, 3'd2, 3, 0, 1);
      do_write(32'h8000_0014, 2'd2, 32'h0BAD_F00D, 4'hF, 3'd2, 0, 2, 0);

      // SLVERR still returns data.
      do_read(1'b1, 32'h8000_0020, 2'd2, 32'hCAFE_F00D, 2'b10, 1, 2);

      // Reset while the read address is pending.
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0040; data_size = 2'd2;
      #1;
      chk("rstmid_addr_ok", 32'(data_addr_ok), 32'd1);
      @(posedge clk); #1;
      data_req = 1'b0;
      chk("rstmid_arvalid_pre", 32'(arvalid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_arvalid", 32'(arvalid), 32'd0);
      chk("rstmid_data_ok", 32'(data_data_ok), 32'd0);
      rvalid = 1'b1; rdata = 32'h7777_7777;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rstmid_quiet", 32'({arvalid, rready, inst_data_ok, data_data_ok}), 32'd0);
      end
      rst = 1'b0; rvalid = 1'b0;
      @(posedge clk); #1;
      do_read(1'b1, 32'h8000_0044, 2'd1, 32'h0000_BEEF, 2'b00, 0, 0);

      // Randomized traffic against the transaction model.
      for (int n = 0; n < 40; n++) begin
         bit          d, w;
         logic [31:0] a, v;
         logic [1:0]  sz;
         d  = 1'($urandom);
         w  = d && 1'($urandom);
         a  = $urandom;
         v  = $urandom;
         if (w) begin
            sz = 2'($urandom_range(0, 3));
            do_write(a, sz, v, model_strb(sz, a), {1'b0, sz},
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            sz = 2'($urandom_range(0, 2));
            do_read(d, a, sz, v, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
